// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared types and frame constants for the MCP3204-class ADC
// SPI master. A frame is the 5 command bits, the sample and null bit
// (together PRE_DATA_BITS clocks before data), then RES_BITS result bits.
package adc_spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int CMD_BITS      = 5;
  localparam int PRE_DATA_BITS = 7;

  // Number of SCLK periods in one conversion frame
  function automatic int frame_len(input int res);
    return PRE_DATA_BITS + res;
  endfunction

endpackage

// File: rtl/clk_div_tick.sv
// clk_div_tick: pulses tick for one clk every DIV clks while en is high.
// The counter is held at zero whenever en is low, so every enable starts a
// full DIV-clk interval before the first tick.
module clk_div_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r;
  logic             wrap_s;

  // Wrap detect on the last count of the interval
  always_comb begin
    wrap_s = 1'b0;
    if (en && (cnt_r == CNT_LAST)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
  end

  assign tick = wrap_s;

  // Interval counter: counts while enabled, clears when idle or on wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (!en) begin
      cnt_r <= CNT_ZERO;
    end else if (wrap_s) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end
  end

endmodule

// File: rtl/adc_spi_ctrl.sv
// adc_spi_ctrl: SPI master (mode 0,0) for an MCP3204-class SAR ADC.
// Frames a start bit, single/differential flag and 3-bit channel on mosi,
// captures RES_BITS result bits MSB first on miso, and hands the result to
// the sample logger with a one-cycle data_valid pulse.
// Optional build macro ADC_SCAN_EN adds a scan_en input that chains
// conversions over the channels back to back without returning to IDLE.
module adc_spi_ctrl
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV  = 500,
  parameter int RES_BITS = 12,
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CH_W-1:0]     ch_sel,
  input  logic                single_ended,
  output logic                busy,
  output logic                data_valid,
  output logic [RES_BITS-1:0] data,
  output logic [CH_W-1:0]     data_ch,
  output logic                sclk,
  output logic                cs_n,
  output logic                mosi,
  input  logic                miso
`ifdef ADC_SCAN_EN
  ,
  input  logic                scan_en
`endif
);

  localparam int              FRAME     = frame_len(RES_BITS);
  localparam int              K_W       = 5;
  localparam logic [K_W-1:0]  K_ZERO    = {K_W{1'b0}};
  localparam logic [K_W-1:0]  K_LAST    = K_W'(FRAME - 1);
  localparam logic [K_W-1:0]  K_CAP_LO  = K_W'(PRE_DATA_BITS);
  localparam logic [K_W-1:0]  K_CAP_HI  = K_W'(PRE_DATA_BITS + RES_BITS - 1);
  localparam logic [K_W-1:0]  K_CMD_END = K_W'(CMD_BITS);
  localparam logic [CH_W-1:0] CH_MAX    = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] CH_ZERO   = {CH_W{1'b0}};
  localparam logic [RES_BITS-1:0] RES_ZERO = {RES_BITS{1'b0}};

  // Command bit driven on mosi while bit index idx is on the wire
  function automatic logic cmd_bit(input logic [K_W-1:0] idx,
                                   input logic           se,
                                   input logic [2:0]     ch3);
    logic b;
    case (idx)
      5'd0:    b = 1'b1;
      5'd1:    b = se;
      5'd2:    b = ch3[2];
      5'd3:    b = ch3[1];
      5'd4:    b = ch3[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic                tick_s;
  logic                div_en_s;
  logic                scan_go_s;

  logic                sclk_r,       sclk_nxt_s;
  logic                cs_n_r,       cs_n_nxt_s;
  logic                mosi_r,       mosi_nxt_s;
  logic                busy_r,       busy_nxt_s;
  logic                dv_r,         dv_nxt_s;
  logic [RES_BITS-1:0] data_r,       data_nxt_s;
  logic [CH_W-1:0]     data_ch_r,    data_ch_nxt_s;
  logic [K_W-1:0]      k_r,          k_nxt_s;
  logic [CH_W-1:0]     ch_r,         ch_nxt_s;
  logic                se_r,         se_nxt_s;
  logic [RES_BITS-1:0] shift_r,      shift_nxt_s;

  logic [CH_W-1:0]     ch_clamp_s;
  logic [CH_W-1:0]     ch_next_s;
  logic [2:0]          ch3_s;
  logic [K_W-1:0]      k_inc_s;

`ifdef ADC_SCAN_EN
  assign scan_go_s = scan_en;
`else
  assign scan_go_s = 1'b0;
`endif

  // The half-period divider only runs in the timed states; DONE and IDLE
  // hold it at zero so each new frame gets a full CS setup interval.
  assign div_en_s = (state_r == CS_SETUP) || (state_r == SHIFT) ||
                    (state_r == CS_HOLD);

  clk_div_tick #(
    .DIV (CLK_DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en_s),
    .tick (tick_s)
  );

  // Channel helpers: clamp out-of-range requests, wrap for scanning,
  // and zero-extend to the 3-bit field the ADC command expects
  always_comb begin
    ch_clamp_s = ch_sel;
    ch_next_s  = CH_ZERO;
    if (ch_sel > CH_MAX) begin
      ch_clamp_s = CH_MAX;
    end else begin
      ch_clamp_s = ch_sel;
    end
    if (ch_r == CH_MAX) begin
      ch_next_s = CH_ZERO;
    end else begin
      ch_next_s = ch_r + CH_W'(1'b1);
    end
    ch3_s   = 3'(ch_r);
    k_inc_s = k_r + 5'd1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = CS_SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CS_SETUP: begin
        if (tick_s) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = CS_SETUP;
        end
      end
      SHIFT: begin
        if (tick_s && sclk_r && (k_r == K_LAST)) begin
          state_nxt_s = CS_HOLD;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      CS_HOLD: begin
        if (tick_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CS_HOLD;
        end
      end
      DONE: begin
        if (scan_go_s) begin
          state_nxt_s = CS_SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output/datapath next values; every pin is registered below
  always_comb begin
    sclk_nxt_s    = sclk_r;
    cs_n_nxt_s    = cs_n_r;
    mosi_nxt_s    = mosi_r;
    busy_nxt_s    = busy_r;
    dv_nxt_s      = 1'b0;
    data_nxt_s    = data_r;
    data_ch_nxt_s = data_ch_r;
    k_nxt_s       = k_r;
    ch_nxt_s      = ch_r;
    se_nxt_s      = se_r;
    shift_nxt_s   = shift_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          ch_nxt_s    = ch_clamp_s;
          se_nxt_s    = single_ended;
          busy_nxt_s  = 1'b1;
          cs_n_nxt_s  = 1'b0;
          mosi_nxt_s  = 1'b1;
          sclk_nxt_s  = 1'b0;
          k_nxt_s     = K_ZERO;
          shift_nxt_s = RES_ZERO;
        end else begin
          busy_nxt_s  = 1'b0;
        end
      end
      CS_SETUP: begin
        sclk_nxt_s = 1'b0;
      end
      SHIFT: begin
        if (tick_s) begin
          if (!sclk_r) begin
            // Rising edge: ADC has its bit stable, sample it
            sclk_nxt_s = 1'b1;
            if ((k_r >= K_CAP_LO) && (k_r <= K_CAP_HI)) begin
              shift_nxt_s = {shift_r[RES_BITS-2:0], miso};
            end else begin
              shift_nxt_s = shift_r;
            end
          end else begin
            // Falling edge: advance the bit index and present the next command bit
            sclk_nxt_s = 1'b0;
            if (k_r == K_LAST) begin
              cs_n_nxt_s = 1'b1;
              mosi_nxt_s = 1'b0;
            end else begin
              k_nxt_s = k_inc_s;
              if (k_inc_s < K_CMD_END) begin
                mosi_nxt_s = cmd_bit(k_inc_s, se_r, ch3_s);
              end else begin
                mosi_nxt_s = 1'b0;
              end
            end
          end
        end else begin
          sclk_nxt_s = sclk_r;
        end
      end
      CS_HOLD: begin
        if (tick_s) begin
          dv_nxt_s      = 1'b1;
          data_nxt_s    = shift_r;
          data_ch_nxt_s = ch_r;
        end else begin
          dv_nxt_s      = 1'b0;
        end
      end
      DONE: begin
        if (scan_go_s) begin
          ch_nxt_s    = ch_next_s;
          busy_nxt_s  = 1'b1;
          cs_n_nxt_s  = 1'b0;
          mosi_nxt_s  = 1'b1;
          sclk_nxt_s  = 1'b0;
          k_nxt_s     = K_ZERO;
          shift_nxt_s = RES_ZERO;
        end else begin
          busy_nxt_s  = 1'b0;
        end
      end
      default: begin
        sclk_nxt_s = 1'b0;
        cs_n_nxt_s = 1'b1;
        mosi_nxt_s = 1'b0;
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      mosi_r    <= 1'b0;
      busy_r    <= 1'b0;
      dv_r      <= 1'b0;
      data_r    <= RES_ZERO;
      data_ch_r <= CH_ZERO;
      k_r       <= K_ZERO;
      ch_r      <= CH_ZERO;
      se_r      <= 1'b0;
      shift_r   <= RES_ZERO;
    end else begin
      sclk_r    <= sclk_nxt_s;
      cs_n_r    <= cs_n_nxt_s;
      mosi_r    <= mosi_nxt_s;
      busy_r    <= busy_nxt_s;
      dv_r      <= dv_nxt_s;
      data_r    <= data_nxt_s;
      data_ch_r <= data_ch_nxt_s;
      k_r       <= k_nxt_s;
      ch_r      <= ch_nxt_s;
      se_r      <= se_nxt_s;
      shift_r   <= shift_nxt_s;
    end
  end

  assign sclk       = sclk_r;
  assign cs_n       = cs_n_r;
  assign mosi       = mosi_r;
  assign busy       = busy_r;
  assign data_valid = dv_r;
  assign data       = data_r;
  assign data_ch    = data_ch_r;

endmodule
